regfile_write_sequencer: RTL

Controller for the integer register file's single write port. Straight after reset it sweeps all 32 architectural registers to zero. It then arbitrates writeback requests from two sources, the ALU/execute stage and the load/memory stage, using round-robin. It drops writes to x0 and drives registered `regwrite`/`rd`/`writedata` into the register file.

---
 rtl/regfile_write_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-port controller for the integer register file: clears every register
// after reset, then round-robin arbitrates ALU and load writebacks.
`timescale 1ns/1ps
module regfile_write_sequencer #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    output logic            rf_regwrite,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_writedata,
    output logic            init_busy
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic          GRANT_ALU = 1'b0;
    localparam logic          GRANT_LD  = 1'b1;
    localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

    state_t          state, state_next;
    logic [AW-1:0]   cnt;
    logic            last_grant;
    logic            alu_fire, ld_fire, contended;
    logic            win_vld_p0;
    logic [AW-1:0]   win_rd_p0;
    logic [XLEN-1:0] win_data_p0;

    // Stage 0: arbitration. A ready only looks at the other source's valid.
    always_comb begin
        state_next = state;
        alu_ready  = 1'b0;
        ld_ready   = 1'b0;
        if (state == RUN) begin
            alu_ready = !ld_valid  || (last_grant == GRANT_LD);
            ld_ready  = !alu_valid || (last_grant == GRANT_ALU);
        end else if (cnt == LAST_IDX) begin
            state_next = RUN;
        end
    end

    assign init_busy   = (state == INIT);
    assign alu_fire    = alu_valid && alu_ready;
    assign ld_fire     = ld_valid && ld_ready;
    assign contended   = alu_valid && ld_valid && (state == RUN);
    assign win_vld_p0  = alu_fire || ld_fire;
    assign win_rd_p0   = alu_fire ? alu_rd : ld_rd;
    assign win_data_p0 = alu_fire ? alu_data : ld_data;

    // Stage 1: registered write port toward the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= INIT;
            cnt          <= '0;
            last_grant   <= GRANT_ALU;
            rf_regwrite  <= 1'b0;
            rf_rd        <= '0;
            rf_writedata <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                rf_regwrite  <= 1'b1;
                rf_rd        <= cnt;
                rf_writedata <= '0;
                cnt          <= cnt + 1'b1;
            end else begin
                if (contended) begin
                    last_grant <= ld_fire ? GRANT_LD : GRANT_ALU;
                end
                if (win_vld_p0) begin
                    rf_regwrite  <= (win_rd_p0 != '0);
                    rf_rd        <= win_rd_p0;
                    rf_writedata <= win_data_p0;
                end else begin
                    rf_regwrite <= 1'b0;
                end
            end
        end
    end

endmodule
